// File: rtl/instr_executor.sv
// Execution stage: runs one 12-bit instruction against an 8 x 4-bit
// register file, then holds the display context for a dwell time.
module instr_executor #(
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [11:0] instr,
    output logic        instr_ready,
    output logic [1:0]  display_op,
    output logic [8:0]  instruction_operands,
    output logic [3:0]  Memory [7:0],
    output logic        flag_cv,
    output logic        err
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SCAN = 3'b011;
    localparam logic [2:0] OP_LDI  = 3'b100;

    localparam logic [26:0] HOLD_LOAD = 27'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        HOLD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [11:0] ir_q;
    logic [4:0]  res_q;
    logic [26:0] cnt_q;

    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [4:0]  alu;
    logic [2:0]  op;
    logic        wr_en;
    logic        arith;
    logic        illegal;
    logic [1:0]  dop;

    assign op = ir_q[11:9];

    // Operands are read and evaluated on the accept edge so the
    // writeback lands exactly one edge after the handshake.
    always_comb begin
        ra  = Memory[instr[5:3]];
        rb  = Memory[instr[2:0]];
        alu = '0;
        unique case (instr[11:9])
            OP_ADD:  alu = {1'b0, ra} + {1'b0, rb};
            OP_SUB:  alu = {1'b0, ra} - {1'b0, rb};
            OP_LDI:  alu = {1'b0, instr[3:0]};
            default: alu = '0;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        arith   = 1'b0;
        illegal = 1'b0;
        dop     = 2'd0;
        unique case (1'b1)
            op == OP_ADD:  begin wr_en = 1'b1; arith = 1'b1; dop = 2'd1; end
            op == OP_SUB:  begin wr_en = 1'b1; arith = 1'b1; dop = 2'd2; end
            op == OP_SCAN: dop = 2'd3;
            op == OP_LDI:  wr_en = 1'b1;
            op == OP_NOP:  dop = 2'd0;
            default:       illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = reset && (state_q == IDLE);
        unique case (state_q)
            IDLE:    if (instr_valid) state_d = WB;
            WB:      state_d = HOLD;
            HOLD:    if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q              <= IDLE;
            ir_q                 <= '0;
            res_q                <= '0;
            cnt_q                <= '0;
            display_op           <= '0;
            instruction_operands <= '0;
            flag_cv              <= 1'b0;
            err                  <= 1'b0;
            for (int i = 0; i < 8; i++) Memory[i] <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        ir_q  <= instr;
                        res_q <= alu;
                    end
                end
                WB: begin
                    if (wr_en) Memory[ir_q[8:6]] <= res_q[3:0];
                    if (arith) flag_cv <= res_q[4];
                    if (illegal) err <= 1'b1;
                    display_op           <= dop;
                    instruction_operands <= ir_q[8:0];
                    cnt_q                <= HOLD_LOAD;
                end
                HOLD: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 27'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_executor.sv
// Bench for instr_executor: directed program plus random instructions
// checked against an arithmetic model of the register file.
module tb_instr_executor;

    localparam int HC = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [11:0] instr = '0;
    logic        instr_ready;
    logic [1:0]  display_op;
    logic [8:0]  instruction_operands;
    logic [3:0]  Memory [7:0];
    logic        flag_cv;
    logic        err;

    int checks = 0;
    int errors = 0;

    int m_r [8];
    int m_op;
    int m_ops;
    int m_cv;
    int m_err;

    instr_executor #(.HOLD_CYCLES(HC)) dut (
        .CLK                  (CLK),
        .reset                (reset),
        .instr_valid          (instr_valid),
        .instr                (instr),
        .instr_ready          (instr_ready),
        .display_op           (display_op),
        .instruction_operands (instruction_operands),
        .Memory               (Memory),
        .flag_cv              (flag_cv),
        .err                  (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_op = 0; m_ops = 0; m_cv = 0; m_err = 0;
    endtask

    task automatic model(input logic [11:0] i);
        int op, d, a, b, s;
        op = int'(i[11:9]);
        d = int'(i[8:6]);
        a = int'(i[5:3]);
        b = int'(i[2:0]);
        m_ops = int'(i[8:0]);
        case (op)
            0: m_op = 0;
            1: begin
                s = m_r[a] + m_r[b];
                m_cv = (s > 15) ? 1 : 0;
                m_r[d] = s % 16;
                m_op = 1;
            end
            2: begin
                s = m_r[a] - m_r[b];
                m_cv = (s < 0) ? 1 : 0;
                m_r[d] = (s + 16) % 16;
                m_op = 2;
            end
            3: m_op = 3;
            4: begin
                m_r[d] = int'(i[3:0]);
                m_op = 0;
            end
            default: begin
                m_err = 1;
                m_op = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".op"}, int'(display_op), m_op);
        chk({tag, ".opnd"}, int'(instruction_operands), m_ops);
        chk({tag, ".cv"}, int'(flag_cv), m_cv);
        chk({tag, ".err"}, int'(err), m_err);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.R%0d", tag, i), int'(Memory[i]), m_r[i]);
    endtask

    function automatic logic [11:0] mk(
        input int op, input int d, input int a, input int b);
        return {3'(op), 3'(d), 3'(a), 3'(b)};
    endfunction

    task automatic send(input logic [11:0] i, input string tag);
        int n;
        int old_ops;
        n = 0;
        @(negedge CLK);
        instr = i;
        instr_valid = 1'b1;
        while (!instr_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, ".wait"}, (n < 100) ? 1 : 0, 1);
        if (n >= 100) begin
            instr_valid = 1'b0;
            return;
        end
        old_ops = m_ops;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        instr = 12'($urandom);
        chk({tag, ".rdy_lo"}, int'(instr_ready), 0);
        chk({tag, ".early"}, int'(instruction_operands), old_ops);
        model(i);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        int last;
        int acc;
        logic [11:0] nxt;
        model_reset();
        #1;
        chk("rst_rdy", int'(instr_ready), 0);
        repeat (3) @(negedge CLK);
        check_all("rst");
        reset = 1'b1;
        @(negedge CLK);
        chk("rdy_after_rst", int'(instr_ready), 1);

        send(mk(4, 2, 0, 9), "ldi_r2");
        send(mk(4, 3, 1, 4), "ldi_r3");
        send(mk(1, 1, 2, 3), "add");
        send(mk(2, 4, 2, 3), "sub1");
        send(mk(2, 5, 3, 2), "sub2");
        send(mk(4, 1, 0, 7), "ldi_r1");
        send(mk(1, 1, 1, 1), "alias");
        send(mk(3, 0, 2, 5), "scan");
        send(mk(6, 1, 2, 3), "illegal");
        send(mk(0, 0, 0, 0), "nop");

        send(mk(4, 6, 1, 5), "pre_rst");
        @(negedge CLK);
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_rdy", int'(instr_ready), 0);
        check_all("midrst");
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        chk("midrst_rdy_hi", int'(instr_ready), 1);

        // continuous valid: garbage while not ready must be ignored
        last = -1;
        acc = 0;
        instr_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (instr_ready) begin
                if (last >= 0) chk("spacing", c - last, HC + 2);
                last = c;
                acc++;
                nxt = mk(4, $urandom_range(0, 7), 0,
                         $urandom_range(0, 7));
                nxt[3:0] = 4'($urandom);
                instr = nxt;
                model(nxt);
            end else begin
                instr = {3'b111, 9'($urandom)};
            end
            @(negedge CLK);
        end
        instr_valid = 1'b0;
        chk("accepts", acc, 7);
        repeat (10) @(negedge CLK);
        check_all("stream");

        for (int k = 0; k < 40; k++) begin
            nxt = 12'($urandom);
            if (k < 30 && nxt[11]) nxt[10:9] = 2'b00;
            send(nxt, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
